// File: rtl/mult_useq_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative multiplier:
//   - state_t : 2-bit FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - clog2() : width of a counter able to index 0..value-1 (minimum 1 bit)
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bits needed to index 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/mult_useq.sv
// ---------------------------------------------------------------------------
// mult_useq
// Radix-2 shift-add multiplier: unsigned WA-bit A times WB-bit B, where B is
// unsigned or two's complement per operation. One partial product per clock,
// WB RUN cycles, then a one-cycle DONE pulse with the product.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : request, sampled only in IDLE or DONE
//   a        : WA-bit multiplicand (unsigned)
//   b        : WB-bit multiplier
//   b_signed : 1 = b is two's complement for this operation
//   busy     : high during the WB RUN cycles
//   done     : one-cycle pulse, result valid from this cycle
//   result   : WA+WB-bit product, held until the next done
// ---------------------------------------------------------------------------
module mult_useq
    import mult_pkg::*;
#(
    parameter int WA = 8,
    parameter int WB = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    input  logic             b_signed,
    output logic             busy,
    output logic             done,
    output logic [WA+WB-1:0] result
);

    localparam int WR = WA + WB;
    localparam int CW = clog2(WB);

    state_t          state_q, state_d;
    logic [WA-1:0]   a_q, a_d;
    logic [WB-1:0]   b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [WR-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WR-1:0]   result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [WR-1:0]   addend_s;
    logic            last_s;

    // Partial product for the current bit position and last-bit detect.
    always_comb begin
        addend_s = {{WB{1'b0}}, a_q} << cnt_q;
        last_s   = (cnt_q == CW'(WB - 1));
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = b_signed;
                    acc_d   = {WR{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The MSB of a signed multiplier has weight -2^(WB-1), so the
                // final partial product is subtracted in signed mode.
                if (b_q[cnt_q]) begin
                    if (last_s && sgn_q) begin
                        acc_d = acc_q - addend_s;
                    end else begin
                        acc_d = acc_q + addend_s;
                    end
                end else begin
                    acc_d = acc_q;
                end
                cnt_d = cnt_q + CW'(1'b1);
                if (last_s) begin
                    result_d = acc_d;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, operand, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= {WA{1'b0}};
            b_q      <= {WB{1'b0}};
            sgn_q    <= 1'b0;
            acc_q    <= {WR{1'b0}};
            cnt_q    <= {CW{1'b0}};
            result_q <= {WR{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mult_useq.sv
// ---------------------------------------------------------------------------
// tb_mult_useq
// Directed self-checking bench for mult_useq with three instances:
// 8x8 (main), 12x8 (wide A) and 4x16 (long B, reference-product sweep).
// ---------------------------------------------------------------------------
module tb_mult_useq;

    logic clk;
    logic rst;

    // 8x8 instance
    logic        start8, bs8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    // 12x8 instance
    logic        start12, bs12, busy12, done12;
    logic [11:0] a12;
    logic [7:0]  b12;
    logic [19:0] res12;

    // 4x16 instance
    logic        start4, bs4, busy4, done4;
    logic [3:0]  a4;
    logic [15:0] b4;
    logic [19:0] res4;

    int checks;
    int errors;

    mult_useq #(.WA(8), .WB(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .b_signed(bs8), .busy(busy8), .done(done8), .result(res8)
    );

    mult_useq #(.WA(12), .WB(8)) u_dut12 (
        .clk(clk), .rst(rst), .start(start12), .a(a12), .b(b12),
        .b_signed(bs12), .busy(busy12), .done(done12), .result(res12)
    );

    mult_useq #(.WA(4), .WB(16)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .b_signed(bs4), .busy(busy4), .done(done4), .result(res4)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8x8 operation; operands are scrambled and start is pulsed during
    // RUN, neither of which may affect the result.
    task automatic run_op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                           input logic is, input logic [15:0] exp);
        int n;
        int nbusy;
        bit ovl;
        nbusy = 0;
        ovl   = 1'b0;
        @(negedge clk);
        a8 = ia; b8 = ib; bs8 = is; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~ia; b8 = ~ib; bs8 = ~is;
        for (n = 1; n < 40; n++) begin
            if (busy8 && done8) ovl = 1'b1;
            if (done8) break;
            if (busy8) nbusy++;
            if (n == 3) start8 = 1'b1;
            if (n == 5) start8 = 1'b0;
            @(negedge clk);
        end
        check_eq({tag, " latency"}, 64'(n), 64'd9);
        check_eq({tag, " busy cycles"}, 64'(nbusy), 64'd8);
        check_eq({tag, " busy&done"}, 64'(ovl), 64'd0);
        check_eq({tag, " result"}, 64'(res8), 64'(exp));
        @(negedge clk);
        check_eq({tag, " done width"}, 64'(done8), 64'd0);
        check_eq({tag, " result held"}, 64'(res8), 64'(exp));
    endtask

    initial begin
        int n;
        int ndone;
        logic [31:0] prod;
        logic signed [31:0] sa, sb;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bs8 = 1'b0;
        start12 = 1'b0; a12 = 12'd0; b12 = 8'd0; bs12 = 1'b0;
        start4 = 1'b0; a4 = 4'd0; b4 = 16'd0; bs4 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 64'(busy8), 64'd0);
        check_eq("reset done", 64'(done8), 64'd0);
        check_eq("reset result", 64'(res8), 64'd0);
        rst = 1'b0;

        // Signed mode
        run_op8("s 55x55", 8'h55, 8'h55, 1'b1, 16'h1C39);

        // Reset three cycles into RUN aborts with result cleared
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h55; bs8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("abort result", 64'(res8), 64'd0);
        check_eq("abort busy", 64'(busy8), 64'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        check_eq("abort no done", 64'(ndone), 64'd0);

        run_op8("s AAxAA", 8'hAA, 8'hAA, 1'b1, 16'hC6E4);
        run_op8("s FFx80", 8'hFF, 8'h80, 1'b1, 16'h8080);
        run_op8("s 55xFF", 8'h55, 8'hFF, 1'b1, 16'hFFAB);
        run_op8("s FFx7F", 8'hFF, 8'h7F, 1'b1, 16'h7E81);
        run_op8("s 00x81", 8'h00, 8'h81, 1'b1, 16'h0000);

        // Unsigned mode
        run_op8("u FFx80", 8'hFF, 8'h80, 1'b0, 16'h7F80);
        run_op8("u FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op8("u AAx81", 8'hAA, 8'h81, 1'b0, 16'h55AA);

        // rst and start together: start is dropped
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; bs8 = 1'b0;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        check_eq("rst+start busy", 64'(busy8), 64'd0);
        @(negedge clk);
        check_eq("rst+start busy next", 64'(busy8), 64'd0);
        check_eq("rst+start result", 64'(res8), 64'd0);

        // start held high: one result every 9 cycles
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h55; bs8 = 1'b1; start8 = 1'b1;
        ndone = 0;
        for (n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                check_eq("b2b spacing", 64'(n % 9), 64'd0);
                check_eq("b2b result", 64'(res8), 64'h1C39);
            end
        end
        start8 = 1'b0;
        check_eq("b2b done count", 64'(ndone), 64'd4);
        repeat (12) @(negedge clk);

        // 12x8: 0xFFF * -128 = -524160 = 0x80080 in 20 bits
        @(negedge clk);
        a12 = 12'hFFF; b12 = 8'h80; bs12 = 1'b1; start12 = 1'b1;
        @(negedge clk);
        start12 = 1'b0;
        for (n = 1; n < 40; n++) begin
            if (done12) break;
            @(negedge clk);
        end
        check_eq("w12 latency", 64'(n), 64'd9);
        check_eq("w12 result", 64'(res12), 64'h80080);

        // 4x16: random operands against a reference product
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            a4 = 4'($urandom_range(15, 0));
            b4 = 16'($urandom_range(65535, 0));
            bs4 = 1'($urandom_range(1, 0));
            start4 = 1'b1;
            sa = $signed({28'd0, a4});
            sb = bs4 ? $signed({{16{b4[15]}}, b4}) : $signed({16'd0, b4});
            prod = 32'(sa * sb);
            @(negedge clk);
            start4 = 1'b0;
            for (n = 1; n < 40; n++) begin
                if (done4) break;
                @(negedge clk);
            end
            check_eq("r4x16 latency", 64'(n), 64'd17);
            check_eq("r4x16 result", 64'(res4), 64'(prod[19:0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
